// File: rtl/ad9833_pkg.sv
// Shared constants for the AD9833 serial receive path: address codes, CTRL bit positions,
// receiver FSM states and frame width.
package ad9833_pkg;

  localparam int FRAME_W = 16;

  localparam logic [1:0] ADDR_CTRL  = 2'b00;
  localparam logic [1:0] ADDR_FREQ0 = 2'b01;
  localparam logic [1:0] ADDR_FREQ1 = 2'b10;
  localparam logic [1:0] ADDR_PHASE = 2'b11;

  localparam int CTRL_B28   = 13;
  localparam int CTRL_HLB   = 12;
  localparam int CTRL_FSEL  = 11;
  localparam int CTRL_PSEL  = 10;
  localparam int CTRL_RESET = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ad9833_reg_decode.sv
// Decodes completed 16-bit frames into the AD9833 shadow register file, including the
// two-write B28 frequency sequence (LSB word staged, MSB word commits).
module ad9833_reg_decode
  import ad9833_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [FRAME_W-1:0]   i_word,
  input  logic                 i_valid,
  output logic [13:0]          o_ctrl,
  output logic [27:0]          o_freq0,
  output logic [27:0]          o_freq1,
  output logic [11:0]          o_phase0,
  output logic [11:0]          o_phase1
);

  logic [13:0] r_ctrl;
  logic [27:0] r_freq0;
  logic [27:0] r_freq1;
  logic [11:0] r_phase0;
  logic [11:0] r_phase1;
  logic [13:0] r_stage;
  logic        r_pend;
  logic [1:0]  r_pend_addr;

  logic [1:0]  w_addr;
  logic [13:0] w_data;

  assign w_addr = i_word[15:14];
  assign w_data = i_word[13:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl      <= '0;
      r_freq0     <= '0;
      r_freq1     <= '0;
      r_phase0    <= '0;
      r_phase1    <= '0;
      r_stage     <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
    end else if (i_valid) begin
      case (w_addr)
        ADDR_CTRL: begin
          r_ctrl <= w_data;
          r_pend <= 1'b0;
        end
        ADDR_FREQ0, ADDR_FREQ1: begin
          if (r_ctrl[CTRL_B28]) begin
            // a write to the other register while pending restarts the pair
            if (r_pend && (r_pend_addr == w_addr)) begin
              if (w_addr == ADDR_FREQ0) r_freq0 <= {w_data, r_stage};
              else                      r_freq1 <= {w_data, r_stage};
              r_pend <= 1'b0;
            end else begin
              r_stage     <= w_data;
              r_pend      <= 1'b1;
              r_pend_addr <= w_addr;
            end
          end else if (r_ctrl[CTRL_HLB]) begin
            if (w_addr == ADDR_FREQ0) r_freq0[27:14] <= w_data;
            else                      r_freq1[27:14] <= w_data;
          end else begin
            if (w_addr == ADDR_FREQ0) r_freq0[13:0] <= w_data;
            else                      r_freq1[13:0] <= w_data;
          end
        end
        default: begin
          if (w_data[13]) r_phase1 <= w_data[11:0];
          else            r_phase0 <= w_data[11:0];
        end
      endcase
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_freq0  = r_freq0;
  assign o_freq1  = r_freq1;
  assign o_phase0 = r_phase0;
  assign o_phase1 = r_phase1;

endmodule

// File: rtl/ad9833_spi_rx.sv
// AD9833 3-wire receiver: synchronises SCLK/FSYNC/SDATA, deserialises 16-bit frames and
// feeds the register decoder. Define AD9833_RX_TIMEOUT_EN to abort frames whose SCLK stalls.
module ad9833_spi_rx
  import ad9833_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         sys_clk_i,
  input  logic         rst_n_i,
  input  logic         SCLK,
  input  logic         FSYNC,
  input  logic         SDATA,
  output logic [15:0]  rx_word_o,
  output logic         rx_word_valid_o,
  output logic         frame_err_o,
  output logic         rx_busy_o,
  output logic [13:0]  ctrl_reg_o,
  output logic [27:0]  freq0_reg_o,
  output logic [27:0]  freq1_reg_o,
  output logic [11:0]  phase0_reg_o,
  output logic [11:0]  phase1_reg_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_fsync_s1, r_fsync_s2, r_fsync_d;
  logic r_sdata_s1, r_sdata_s2;

  rx_state_t          r_state;
  logic [FRAME_W-1:0] r_shift;
  logic [3:0]         r_bit_cnt;
  logic [FRAME_W-1:0] r_rx_word;
  logic               r_valid;
  logic               r_err;
`ifdef AD9833_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0]    r_to_cnt;
`endif

  logic               w_sclk_fall, w_sclk_edge, w_fsync_fall, w_fsync_rise;
  logic               w_capture, w_last;
  logic [FRAME_W-1:0] w_shift_next;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sclk_s1  <= 1'b0; r_sclk_s2  <= 1'b0; r_sclk_d  <= 1'b0;
      r_fsync_s1 <= 1'b0; r_fsync_s2 <= 1'b0; r_fsync_d <= 1'b0;
      r_sdata_s1 <= 1'b0; r_sdata_s2 <= 1'b0;
    end else begin
      r_sclk_s1  <= SCLK;  r_sclk_s2  <= r_sclk_s1;  r_sclk_d  <= r_sclk_s2;
      r_fsync_s1 <= FSYNC; r_fsync_s2 <= r_fsync_s1; r_fsync_d <= r_fsync_s2;
      r_sdata_s1 <= SDATA; r_sdata_s2 <= r_sdata_s1;
    end
  end

  assign w_sclk_fall  = r_sclk_d & ~r_sclk_s2;
  assign w_sclk_edge  = r_sclk_d ^ r_sclk_s2;
  assign w_fsync_fall = r_fsync_d & ~r_fsync_s2;
  assign w_fsync_rise = ~r_fsync_d & r_fsync_s2;
  // in S_SHIFT synced FSYNC is low except in the cycle its rise is seen, which still completes bit 16
  assign w_capture    = (r_state == S_SHIFT) && w_sclk_fall;
  assign w_last       = w_capture && (r_bit_cnt == 4'd15);
  assign w_shift_next = {r_shift[FRAME_W-2:0], r_sdata_s2};

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_rx_word <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
`ifdef AD9833_RX_TIMEOUT_EN
      r_to_cnt  <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fsync_fall) begin
            r_state   <= S_SHIFT;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef AD9833_RX_TIMEOUT_EN
            r_to_cnt  <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        S_SHIFT: begin
          if (w_last) begin
            r_shift   <= w_shift_next;
            r_rx_word <= w_shift_next;
            r_valid   <= 1'b1;
            r_state   <= w_fsync_rise ? S_IDLE : S_DONE;
          end else if (w_fsync_rise) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
`ifdef AD9833_RX_TIMEOUT_EN
          end else if (r_to_cnt == '0) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
`endif
          end else begin
            if (w_capture) begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
`ifdef AD9833_RX_TIMEOUT_EN
            if (w_sclk_edge) r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
            else             r_to_cnt <= r_to_cnt - 1'b1;
`endif
          end
        end
        S_DONE: begin
          if (w_fsync_rise) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef AD9833_RX_TIMEOUT_EN
  logic w_unused_edge;
  assign w_unused_edge = w_sclk_edge;
`endif

  ad9833_reg_decode u_decode (
    .i_clk    (sys_clk_i),
    .i_rst_n  (rst_n_i),
    .i_word   (w_shift_next),
    .i_valid  (w_last),
    .o_ctrl   (ctrl_reg_o),
    .o_freq0  (freq0_reg_o),
    .o_freq1  (freq1_reg_o),
    .o_phase0 (phase0_reg_o),
    .o_phase1 (phase1_reg_o)
  );

  assign rx_word_o       = r_rx_word;
  assign rx_word_valid_o = r_valid;
  assign frame_err_o     = r_err;
  assign rx_busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ad9833_spi_rx.sv
// Directed bench for ad9833_spi_rx: a bus master at sys_clk/4, a word scoreboard checked on
// each valid pulse, and register/pulse-count checks after every step.
module tb_ad9833_spi_rx;

  logic        sys_clk_i = 1'b0;
  logic        rst_n_i   = 1'b0;
  logic        SCLK      = 1'b1;
  logic        FSYNC     = 1'b1;
  logic        SDATA     = 1'b0;
  logic [15:0] rx_word_o;
  logic        rx_word_valid_o, frame_err_o, rx_busy_o;
  logic [13:0] ctrl_reg_o;
  logic [27:0] freq0_reg_o, freq1_reg_o;
  logic [11:0] phase0_reg_o, phase1_reg_o;

  int errors  = 0;
  int checks  = 0;
  int n_valid = 0;
  int n_err   = 0;
  logic [15:0] sb_q[$];

  ad9833_spi_rx dut (
    .sys_clk_i       (sys_clk_i),
    .rst_n_i         (rst_n_i),
    .SCLK            (SCLK),
    .FSYNC           (FSYNC),
    .SDATA           (SDATA),
    .rx_word_o       (rx_word_o),
    .rx_word_valid_o (rx_word_valid_o),
    .frame_err_o     (frame_err_o),
    .rx_busy_o       (rx_busy_o),
    .ctrl_reg_o      (ctrl_reg_o),
    .freq0_reg_o     (freq0_reg_o),
    .freq1_reg_o     (freq1_reg_o),
    .phase0_reg_o    (phase0_reg_o),
    .phase1_reg_o    (phase1_reg_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clk_i) begin
    if (frame_err_o) n_err++;
    if (rx_word_valid_o) begin
      n_valid++;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%h expected=none", rx_word_o);
      end
      if (sb_q.size() != 0) begin
        logic [15:0] exp_w;
        exp_w = sb_q.pop_front();
        checks++;
        assert (rx_word_o === exp_w) else begin
          errors++;
          $error("FAIL sb_word observed=%h expected=%h", rx_word_o, exp_w);
        end
      end
    end
  end

  task automatic frame_start();
    @(negedge sys_clk_i) FSYNC = 1'b0;
    repeat (4) @(negedge sys_clk_i);
  endtask

  task automatic send_bits(input logic [19:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SDATA = data[i];
      SCLK  = 1'b1;
      repeat (2) @(negedge sys_clk_i);
      SCLK  = 1'b0;
      repeat (2) @(negedge sys_clk_i);
    end
    SCLK = 1'b1;
  endtask

  task automatic frame_end();
    repeat (4) @(negedge sys_clk_i);
    FSYNC = 1'b1;
    repeat (8) @(negedge sys_clk_i);
  endtask

  task automatic send_word(input logic [15:0] w);
    sb_q.push_back(w);
    frame_start();
    send_bits({4'h0, w}, 16);
    frame_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int v0, e0;
    logic [15:0] w;

    repeat (3) @(negedge sys_clk_i);
    chk("rst_word", rx_word_o, 0);
    chk("rst_busy", rx_busy_o, 0);
    chk("rst_ctrl", ctrl_reg_o, 0);
    chk("rst_freq1", freq1_reg_o, 0);
    rst_n_i = 1'b1;
    repeat (4) @(negedge sys_clk_i);

    // 1: B28 pair into FREQ0
    v0 = n_valid;
    send_word(16'h2100);
    chk("t1_ctrl", ctrl_reg_o, 14'h2100);
    send_word(16'h50C7);
    chk("t1_freq0_staged", freq0_reg_o, 0);
    send_word(16'h4000);
    chk("t1_freq0", freq0_reg_o, 28'h00010C7);
    chk("t1_valids", n_valid - v0, 3);

    // 2: B28=0, HLB=1 upper half of FREQ1
    send_word(16'h1000);
    chk("t2_ctrl", ctrl_reg_o, 14'h1000);
    send_word(16'h8005);
    chk("t2_freq1_hi", freq1_reg_o[27:14], 14'h0005);
    chk("t2_freq1_lo", freq1_reg_o[13:0], 14'h0000);
    chk("t2_freq0", freq0_reg_o, 28'h00010C7);

    // 3: phase registers
    send_word(16'hC000);
    send_word(16'hE123);
    chk("t3_phase0", phase0_reg_o, 12'h000);
    chk("t3_phase1", phase1_reg_o, 12'h123);
    chk("t3_ctrl", ctrl_reg_o, 14'h1000);
    chk("t3_freq1", freq1_reg_o, 28'h0014000);

    // 4: frame aborted after 9 bits
    v0 = n_valid; e0 = n_err;
    w = 16'hE456;
    frame_start();
    send_bits(20'(w >> 7), 9);
    chk("t4_busy", rx_busy_o, 1);
    frame_end();
    chk("t4_err", n_err - e0, 1);
    chk("t4_novalid", n_valid - v0, 0);
    chk("t4_phase1_kept", phase1_reg_o, 12'h123);
    send_word(16'hE456);
    chk("t4_phase1", phase1_reg_o, 12'h456);
    chk("t4_err_total", n_err - e0, 1);

    // 5: B28 restart on address change, then an over-long frame
    v0 = n_valid;
    send_word(16'h2000);
    send_word(16'h4001);
    send_word(16'h8002);
    sb_q.push_back(16'h8003);
    frame_start();
    send_bits({16'h8003, 4'hF}, 20);
    chk("t5_busy_done", rx_busy_o, 1);
    frame_end();
    chk("t5_freq0", freq0_reg_o, 28'h00010C7);
    chk("t5_freq1", freq1_reg_o, {14'h0003, 14'h0002});
    chk("t5_valids", n_valid - v0, 4);
    chk("t5_idle", rx_busy_o, 0);

    // 6: asynchronous reset mid-frame
    v0 = n_valid; e0 = n_err;
    w = 16'hE789;
    frame_start();
    send_bits(20'(w >> 8), 8);
    @(negedge sys_clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("t6_word", rx_word_o, 0);
    chk("t6_busy", rx_busy_o, 0);
    chk("t6_ctrl", ctrl_reg_o, 0);
    chk("t6_freq0", freq0_reg_o, 0);
    chk("t6_freq1", freq1_reg_o, 0);
    chk("t6_phase0", phase0_reg_o, 0);
    chk("t6_phase1", phase1_reg_o, 0);
    repeat (3) @(negedge sys_clk_i);
    rst_n_i = 1'b1;
    repeat (4) @(negedge sys_clk_i);
    FSYNC = 1'b1;
    repeat (8) @(negedge sys_clk_i);
    chk("t6_nopulse_valid", n_valid - v0, 0);
    chk("t6_nopulse_err", n_err - e0, 0);
    send_word(16'hE789);
    send_word(16'h4ABC);
    chk("t6_phase1", phase1_reg_o, 12'h789);
    chk("t6_freq0_lo", freq0_reg_o, 28'h0000ABC);

`ifdef AD9833_RX_TIMEOUT_EN
    e0 = n_err;
    frame_start();
    send_bits(20'h5, 3);
    for (int i = 0; i < 1500 && n_err == e0; i++) @(negedge sys_clk_i);
    chk("to_err", n_err - e0, 1);
    chk("to_idle", rx_busy_o, 0);
    frame_end();
    chk("to_err_once", n_err - e0, 1);
    send_word(16'hC321);
    chk("to_phase0", phase0_reg_o, 12'h321);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
